// File: rtl/bit_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : bit_synchronizer
// Brief    : Per-bit multi-flop synchronizer for level signals entering CLK.
// Revision : 1.0 - initial release
// ============================================================================
module bit_synchronizer #(
  parameter int BUS_WIDTH  = 2,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  output logic [BUS_WIDTH-1:0] SYNC
);

  generate
    if (NUM_STAGES < 2 || NUM_STAGES > 8 || BUS_WIDTH < 1) begin : g_param_check
      $error("bit_synchronizer: NUM_STAGES must be 2..8 and BUS_WIDTH >= 1");
    end
  endgenerate

  // One independent chain per bit; bus bits never interact.
  generate
    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_bit
      (* ASYNC_REG = "TRUE" *) logic [NUM_STAGES-1:0] chain_q;
      logic [NUM_STAGES-1:0] chain_d;

      always_comb begin
        chain_d = {chain_q[NUM_STAGES-2:0], ASYNC[i]};
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          chain_q <= '0;
        end else begin
          chain_q <= chain_d;
        end
      end

      assign SYNC[i] = chain_q[NUM_STAGES-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bit_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_synchronizer
// Brief    : Scoreboard bench for bit_synchronizer (2x2 and 4x3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_synchronizer;

  localparam int NS_A = 2;
  localparam int NS_B = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] async_a;
  logic [1:0] sync_a;
  logic [3:0] async_b;
  logic [3:0] sync_b;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_a_q[$];
  logic [3:0] exp_b_q[$];

  always #5 clk = ~clk;

  bit_synchronizer #(.BUS_WIDTH(2), .NUM_STAGES(NS_A)) u_dut_a (
    .CLK   (clk),
    .RST   (rst),
    .ASYNC (async_a),
    .SYNC  (sync_a)
  );

  bit_synchronizer #(.BUS_WIDTH(4), .NUM_STAGES(NS_B)) u_dut_b (
    .CLK   (clk),
    .RST   (rst),
    .ASYNC (async_b),
    .SYNC  (sync_b)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one edge worth of stimulus; expected SYNC values are queued at
  // drive time and retired when the matching edge has passed.
  task automatic step(input logic r, input logic [1:0] a, input logic [3:0] b, input string tag);
    logic [1:0] ea;
    logic [3:0] eb;
    rst     = r;
    async_a = a;
    async_b = b;
    if (!r) begin
      exp_a_q.push_back(a);
      exp_b_q.push_back(b);
    end
    @(posedge clk);
    #1;
    if (r) begin
      exp_a_q.delete();
      exp_b_q.delete();
      for (int k = 0; k < NS_A - 1; k++) exp_a_q.push_back(2'b00);
      for (int k = 0; k < NS_B - 1; k++) exp_b_q.push_back(4'h0);
      check_value({tag, "_rst_a"}, {30'd0, sync_a}, 32'd0);
      check_value({tag, "_rst_b"}, {28'd0, sync_b}, 32'd0);
    end else begin
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      check_value({tag, "_a"}, {30'd0, sync_a}, {30'd0, ea});
      check_value({tag, "_b"}, {28'd0, sync_b}, {28'd0, eb});
    end
  endtask

  initial begin
    rst     = 1'b1;
    async_a = 2'b11;
    async_b = 4'hF;

    // Reset with inputs high, held across several edges
    step(1'b1, 2'b11, 4'hF, "reset0");
    step(1'b1, 2'b10, 4'h5, "reset1");
    step(1'b1, 2'b01, 4'hA, "reset2");

    // Latency: 00 -> 01 on A, 0 -> A on B
    step(1'b0, 2'b00, 4'h0, "lat0");
    step(1'b0, 2'b01, 4'hA, "lat1");
    check_value("lat_a_edge1", {30'd0, sync_a}, 32'd0);
    step(1'b0, 2'b01, 4'hA, "lat2");
    check_value("lat_a_edge2", {30'd0, sync_a}, 32'd1);
    check_value("lat_b_edge2", {28'd0, sync_b}, 32'd0);
    step(1'b0, 2'b01, 4'hA, "lat3");
    check_value("lat_b_edge3", {28'd0, sync_b}, 32'hA);

    // Hold
    for (int n = 0; n < 5; n++) begin
      step(1'b0, 2'b01, 4'hA, "hold");
      check_value("hold_a", {30'd0, sync_a}, 32'd1);
    end

    // Mid-flight reset: 10 captured then discarded
    step(1'b0, 2'b10, 4'h3, "mid0");
    step(1'b1, 2'b10, 4'h3, "mid_rst");
    for (int n = 0; n < 4; n++) begin
      step(1'b0, 2'b00, 4'h0, "mid_after");
      check_value("mid_no_10", {31'd0, sync_a[1]}, 32'd0);
    end

    // Per-bit independence: bit 0 held high, bit 1 toggles
    step(1'b0, 2'b01, 4'h1, "ind_warm0");
    step(1'b0, 2'b01, 4'h1, "ind_warm1");
    for (int n = 0; n < 8; n++) begin
      step(1'b0, {n[0], 1'b1}, {3'b000, 1'b1}, "ind");
      check_value("ind_bit0", {31'd0, sync_a[0]}, 32'd1);
    end

    // Random traffic with occasional resets
    for (int n = 0; n < 40; n++) begin
      step(($urandom_range(0, 9) == 0), 2'($urandom), 4'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_synchronizer.md
BIT_SYNCHRONIZER -- requirements
Module: bit_synchronizer

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 2: number of independent single-bit signals synchronized.
REQ-002 The block SHALL have parameter NUM_STAGES, default 2: flip-flop stages per bit; legal range 2..8.
REQ-003 The block SHALL have port CLK, input, 1 bit: destination-domain clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous to CLK and active-high.
REQ-005 The block SHALL have port ASYNC, input, BUS_WIDTH bits: asynchronous level inputs from a foreign clock domain.
REQ-006 The block SHALL have port SYNC, output, BUS_WIDTH bits: synchronized copy of ASYNC in the CLK domain.
REQ-007 The block SHALL use one clock, CLK, and one reset, RST, synchronous and active-high.

Function
REQ-008 Each bit i SHALL have its own shift chain of NUM_STAGES flip-flops; no logic between bits.
REQ-009 On each CLK rising edge with RST=0, stage 0 of bit i SHALL capture ASYNC[i], and stage k SHALL capture stage k-1 for k = 1..NUM_STAGES-1.
REQ-010 SYNC[i] SHALL be driven directly by the last stage of chain i, with no combinational path from ASYNC to SYNC.
REQ-011 Latency SHALL be exactly NUM_STAGES CLK rising edges: a value stable on ASYNC before edge n appears on SYNC after edge n+NUM_STAGES-1.
REQ-012 A change on ASYNC SHALL never reach SYNC in fewer than NUM_STAGES edges.
REQ-013 Each bit SHALL be synchronized independently; bits changing together MAY arrive on SYNC in different cycles, and no bus coherency is provided.
REQ-014 A pulse on ASYNC shorter than one CLK period MAY be lost, and no pulse stretching is provided.
REQ-015 An elaboration-time check SHALL flag NUM_STAGES < 2 or BUS_WIDTH < 1 as an error.
REQ-016 The block SHALL contain no gating and no clock or reset manipulation, and chain flops SHALL be marked as synchronizer cells (ASYNC_REG or equivalent attribute).

Reset
REQ-017 On a CLK rising edge with RST=1, every stage of every chain SHALL load 0, so SYNC = 0 after that edge.
REQ-018 Reset SHALL take priority over data capture on the same edge.
REQ-019 While RST stays 1, SYNC SHALL hold 0 regardless of ASYNC.
REQ-020 After RST falls, the first data edge SHALL load stage 0 from ASYNC, and SYNC SHALL reflect ASYNC after NUM_STAGES edges with RST=0.
REQ-021 Reset asserted mid-propagation SHALL discard all in-flight values, and SYNC SHALL be 0 after the reset edge.
REQ-022 Before the first reset edge, SYNC SHALL be undefined, and no initial values SHALL be relied on.

Verification (BUS_WIDTH=2, NUM_STAGES=2 unless stated)
REQ-023 Reset check: RST=1 for one edge with ASYNC=2'b11 -> SYNC=2'b00 after that edge and held while RST=1.
REQ-024 Latency check: RST=0, ASYNC 2'b00->2'b01 -> SYNC=2'b00 after the 1st edge and 2'b01 after the 2nd edge.
REQ-025 Hold check: ASYNC=2'b01 held for 5 edges -> SYNC stays 2'b01 from the 2nd edge on.
REQ-026 Mid-flight reset check: ASYNC=2'b10 one edge, then RST=1 on the next edge -> SYNC=2'b00, and the 2'b10 value never appears.
REQ-027 Parameter check: NUM_STAGES=3, BUS_WIDTH=4, ASYNC=4'hA step -> SYNC=4'hA exactly after the 3rd edge.
REQ-028 Per-bit independence check: toggle only ASYNC[1] -> SYNC[0] unchanged on every edge.
